mem_loader: RTL and testbench
=============================

# mem_loader

Boot-time program loader that sits directly upstream of the 16-bit data/instruction memory. It accepts a byte stream (from a UART or debug port) over a valid/ready handshake and assembles little-endian 16-bit words. Each word is written to consecutive memory addresses starting at 0, and the loader verifies an XOR checksum at the end. The CPU is held off while `busy` is high and released on `done`.

## Interface

Parameters:
- `WIDTH`, default 16: memory word width. Must be 16 (two bytes per word); any other value is an elaboration error.
- `DEPTH`, default 1024: memory depth in words.
- `ADD_SIZE`, default `$clog2(DEPTH)`: memory address width.

Ports:
- `clk`, input, 1: single clock; everything is rising-edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a load. Sampled only in IDLE or DONE/ERR; ignored otherwise.
- `in_data`, input, 8: stream byte.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: loader accepts a byte. A transfer happens when `in_valid && in_ready` at a rising edge.
- `addr`, output, ADD_SIZE: memory address; drives the memory's `addr`.
- `wdata`, output, WIDTH: memory write data.
- `we`, output, 1: memory write enable, a one-cycle pulse per word.
- `busy`, output, 1: a load is in progress.
- `done`, output, 1: the last load completed with a good checksum. Sticky until the next accepted `start` or reset.
- `err`, output, 1: the last load failed (oversize count or bad checksum). Sticky like `done`.

## Operation

- Stream format: `CNT_LO`, `CNT_HI`, then N words each sent as `LO`, `HI`, then `CHK`.
  - N = {CNT_HI, CNT_LO}.
  - CHK is the XOR of every preceding byte, header included.
- FSM states: IDLE, HDR_LO, HDR_HI, DAT_LO, DAT_HI, WRITE, CHK, FIN.
- IDLE/FIN with `start` high:
  - Clear `done`, `err`, the checksum accumulator and the word counter.
  - Go to HDR_LO.
  - Set `busy`.
- HDR_LO: on a transfer, latch the count low byte. Go to HDR_HI.
- HDR_HI: on a transfer, latch the count high byte and check it.
  - N > DEPTH: set `err`, go to FIN.
  - N == 0: go to CHK.
  - Otherwise: go to DAT_LO.
- DAT_LO and DAT_HI: on each transfer, latch the byte into the low or high half of the word register. DAT_HI then goes to WRITE.
- WRITE:
  - `in_ready`=0, `we`=1, `addr`=word counter, `wdata`=assembled word.
  - Next cycle the counter increments. If the counter equals N, go to CHK; else go to DAT_LO.
- CHK: on a transfer, compare the byte with the accumulator.
  - Equal: set `done`.
  - Not equal: set `err`. Writes already performed are not undone.
  - Go to FIN.
- FIN: `busy`=0, `done`/`err` held.
- `in_ready`=1 exactly in HDR_LO, HDR_HI, DAT_LO, DAT_HI and CHK; 0 in all other states.
- The checksum accumulator XORs every accepted byte except CHK itself.
- Width rules:
  - Count register is 16 bits.
  - Word counter is ADD_SIZE+1 bits, so N == DEPTH reaches the last address with no wrap.
  - `addr` is the counter's low ADD_SIZE bits.
- `start` asserted while `busy` is ignored; there is no restart mid-load.

## Timing

- Reset values: `in_ready`=0, `we`=0, `addr`=0, `wdata`=0, `busy`=0, `done`=0, `err`=0. State = IDLE.
- Reset mid-load: all outputs go to their reset values immediately (asynchronous). Partially written memory is left as is.
- `busy` rises on the edge after `start` is accepted. It falls on the edge that enters FIN.
- `we` is high for exactly one cycle per word: the cycle after the HI byte transfer. `addr` and `wdata` are stable during that cycle.
- Back-to-back valid stream: 1 cycle for start + 2 header + 3N + 1 CHK.
- `in_valid` gaps stall the current state with no side effects; `in_data` is ignored when `in_valid`=0.
- Oversize N: `err` rises on the edge that accepts CNT_HI. `in_ready` is 0 from the next cycle, and no `we` is issued.
- `done` and `err` are never both 1.

## Structure

- Package `mem_loader_pkg`:
  - state enum `loader_state_t`;
  - `BYTE_W`=8;
  - `BYTES_PER_WORD`=2.
- Flat single module. No sub-module is needed: the byte packer and the checksum are a few registers inside the FSM.
- Outputs are registered. `we`, `addr` and `wdata` are decoded from the WRITE state and registered data.

## Test plan

- Nominal load: stream `02 00 CD AB 34 12 42` with `in_valid` held high.
  - Expect `we` pulses writing addr 0 = 0xABCD, then addr 1 = 0x1234.
  - Then `done`=1, `err`=0, `busy`=0.
  - Reading the memory back returns 0xABCD and 0x1234.
- Bad checksum: same stream with last byte 0x43.
  - Both writes occur.
  - `err`=1, `done`=0.
- Empty load: stream `00 00 00`.
  - No `we`.
  - `done`=1 after 4 cycles.
- Oversize count: stream `01 04` (N = 1025).
  - `err`=1 on the CNT_HI edge, then `in_ready`=0.
  - No `we`; further bytes are not accepted.
- Backpressure and ignored start: nominal stream with `in_valid` toggling every cycle, and `start` pulsed mid-load.
  - Identical writes and final flags to the nominal case.
  - Load time is longer; the mid-load `start` has no effect.
- Reset mid-load: drive `rst`=0 right after the first `we`.
  - All outputs are 0 immediately.
  - A fresh `start` followed by the nominal stream completes with `done`=1.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package mem_loader_pkg;

   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR_LO,
      ST_HDR_HI,
      ST_DAT_LO,
      ST_DAT_HI,
      ST_WRITE,
      ST_CHK,
      ST_FIN
   } loader_state_t;

   // States in which the loader accepts a stream byte.
   function automatic logic ready_state(input loader_state_t s);
      return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_DAT_LO) ||
             (s == ST_DAT_HI) || (s == ST_CHK);
   endfunction

endpackage

// File: rtl/mem_loader.sv
// Byte-stream program loader: header count, little-endian 16-bit words
// written to consecutive addresses from 0, trailing XOR checksum.
module mem_loader
   import mem_loader_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 1024,
   parameter int ADD_SIZE = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [BYTE_W-1:0]   in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [ADD_SIZE-1:0] addr,
   output logic [WIDTH-1:0]    wdata,
   output logic                we,
   output logic                busy,
   output logic                done,
   output logic                err
);

   if (WIDTH != BYTE_W * BYTES_PER_WORD) begin : g_bad_width
      $error("mem_loader: WIDTH must be 16");
   end

   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   loader_state_t         state_q, state_d;
   logic [15:0]           n_q, n_d;
   logic [BYTE_W-1:0]     lo_q, lo_d;
   logic [BYTE_W-1:0]     acc_q, acc_d;
   logic [ADD_SIZE:0]     cnt_q, cnt_d;
   logic [ADD_SIZE:0]     cnt_inc;
   logic [16:0]           n_hdr;
   logic                  in_ready_q, in_ready_d;
   logic                  we_q, we_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [ADD_SIZE-1:0]   addr_q, addr_d;
   logic [WIDTH-1:0]      wdata_q, wdata_d;
   logic                  xfer;

   assign xfer    = in_valid && in_ready_q;
   assign cnt_inc = cnt_q + 1'b1;
   assign n_hdr   = {1'b0, in_data, n_q[7:0]};

   // Next-state, datapath and registered-output decode for the loader FSM.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      lo_d    = lo_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      unique case (state_q)
         ST_IDLE, ST_FIN: begin
            if (start) begin
               state_d = ST_HDR_LO;
               done_d  = 1'b0;
               err_d   = 1'b0;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         ST_HDR_LO: begin
            if (xfer) begin
               n_d[7:0] = in_data;
               acc_d    = acc_q ^ in_data;
               state_d  = ST_HDR_HI;
            end
         end
         ST_HDR_HI: begin
            if (xfer) begin
               n_d[15:8] = in_data;
               acc_d     = acc_q ^ in_data;
               if (n_hdr > DEPTH_W) begin
                  err_d   = 1'b1;
                  state_d = ST_FIN;
               end else if (n_hdr == '0) begin
                  state_d = ST_CHK;
               end else begin
                  state_d = ST_DAT_LO;
               end
            end
         end
         ST_DAT_LO: begin
            if (xfer) begin
               lo_d    = in_data;
               acc_d   = acc_q ^ in_data;
               state_d = ST_DAT_HI;
            end
         end
         ST_DAT_HI: begin
            if (xfer) begin
               acc_d   = acc_q ^ in_data;
               // Word and address are captured here so they are stable
               // for the whole WRITE cycle.
               wdata_d = WIDTH'({in_data, lo_q});
               addr_d  = cnt_q[ADD_SIZE-1:0];
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            cnt_d   = cnt_inc;
            state_d = (17'(cnt_inc) == {1'b0, n_q}) ? ST_CHK : ST_DAT_LO;
         end
         ST_CHK: begin
            if (xfer) begin
               if (in_data == acc_q) done_d = 1'b1;
               else                  err_d  = 1'b1;
               state_d = ST_FIN;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      in_ready_d = ready_state(state_d);
      busy_d     = (state_d != ST_IDLE) && (state_d != ST_FIN);
      we_d       = (state_d == ST_WRITE);
   end

   // All state and outputs registered; async active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         n_q        <= '0;
         lo_q       <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         in_ready_q <= 1'b0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         lo_q       <= lo_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         in_ready_q <= in_ready_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign in_ready = in_ready_q;
   assign we       = we_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign addr     = addr_q;
   assign wdata    = wdata_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: vector table of whole streams plus
// hand-written oversize and mid-load reset sequences; writes checked
// through an expected-write queue.
module tb_mem_loader;

   localparam int DEPTH = 1024;
   localparam int AW    = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] addr;
   logic [15:0]   wdata;
   logic          we;
   logic          busy;
   logic          done;
   logic          err;

   mem_loader dut (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .addr(addr),
      .wdata(wdata), .we(we), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] b;      // byte i at b[8*i +: 8]
      int          nb;
      bit          gap;    // toggle in_valid every cycle
      bit          mid;    // pulse start mid-load
      logic        exp_done;
      logic        exp_err;
   } vec_t;

   int          n_total = 0;
   int          n_pass  = 0;
   logic [31:0] exp_q[$];
   logic [15:0] mem[DEPTH];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Write monitor: every we pulse must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst && we) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_we", 32'(addr), 32'hFFFF_FFFF);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("write_addr", 32'(addr), 32'(e[31:16]));
            chk("write_data", 32'(wdata), 32'(e[15:0]));
            chk("write_in_ready_low", 32'(in_ready), 32'd0);
         end
         mem[addr] = wdata;
      end
   end

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("flags_clear_after_start", 32'({done, err}), 32'd0);
   endtask

   // Drive nb bytes with handshake; cyc returns edges spent after start.
   task automatic send(input logic [63:0] b, input int nb, input bit gap,
                       input bit mid, output int cyc);
      int  k;
      bit  ok;
      k   = 0;
      cyc = 0;
      while (k < nb && cyc < 200) begin
         in_valid = !(gap && (cyc % 2 == 1));
         in_data  = in_valid ? b[8*k +: 8] : 8'hEE;
         start    = mid && (cyc == 3);
         @(negedge clk);
         ok = in_valid && in_ready;
         @(posedge clk); #1;
         cyc++;
         if (ok) k++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (k < nb) chk("stream_timeout", 32'(k), 32'(nb));
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int n;
      int cyc;
      n = int'({v.b[15:8], v.b[7:0]});
      if (n <= DEPTH && v.nb >= 2*n + 3)
         for (int i = 0; i < n; i++)
            exp_q.push_back({16'(i), v.b[8*(3+2*i) +: 8], v.b[8*(2+2*i) +: 8]});
      do_start();
      send(v.b, v.nb, v.gap, v.mid, cyc);
      chk({name, "_done"}, 32'(done), 32'(v.exp_done));
      chk({name, "_err"}, 32'(err), 32'(v.exp_err));
      chk({name, "_busy"}, 32'(busy), 32'd0);
      chk({name, "_in_ready"}, 32'(in_ready), 32'd0);
      if (!v.gap) chk({name, "_cycles"}, 32'(cyc), 32'(3*n + 3));
      repeat (2) @(posedge clk);
      #1;
      chk({name, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
      chk({name, "_flags_held"}, 32'({done, err}), 32'({v.exp_done, v.exp_err}));
   endtask

   vec_t vecs[5];

   initial begin
      int cyc;
      vecs[0] = '{b: 64'h42_12_34_AB_CD_00_02, nb: 7, gap: 0, mid: 0, exp_done: 1, exp_err: 0};
      vecs[1] = '{b: 64'h43_12_34_AB_CD_00_02, nb: 7, gap: 0, mid: 0, exp_done: 0, exp_err: 1};
      vecs[2] = '{b: 64'h00_00_00,             nb: 3, gap: 0, mid: 0, exp_done: 1, exp_err: 0};
      vecs[3] = '{b: 64'hFE_00_FF_00_01,       nb: 5, gap: 0, mid: 0, exp_done: 1, exp_err: 0};
      vecs[4] = '{b: 64'h42_12_34_AB_CD_00_02, nb: 7, gap: 1, mid: 1, exp_done: 1, exp_err: 0};

      // Reset state
      #12;
      chk("rst_outputs", 32'({in_ready, we, busy, done, err}), 32'd0);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_wdata", 32'(wdata), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", 32'(in_ready), 32'd0);

      for (int i = 0; i < 5; i++) begin
         mem[0] = 16'h0;
         mem[1] = 16'h0;
         run_vec(vecs[i], $sformatf("vec%0d", i));
         if (i == 0 || i == 4) begin
            chk("readback0", 32'(mem[0]), 32'h0000_ABCD);
            chk("readback1", 32'(mem[1]), 32'h0000_1234);
         end
      end

      // Oversize count 0x0401: err on CNT_HI edge, nothing further accepted
      do_start();
      send(64'h04_01, 2, 0, 0, cyc);
      chk("ovr_err", 32'(err), 32'd1);
      chk("ovr_done", 32'(done), 32'd0);
      chk("ovr_busy", 32'(busy), 32'd0);
      chk("ovr_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (4) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("ovr_in_ready_stays_low", 32'(in_ready), 32'd0);
      chk("ovr_err_held", 32'({done, err}), 32'd1);

      // Reset right after the first write pulse
      do_start();
      send(64'hAB_CD_00_02, 4, 0, 0, cyc);
      chk("rstmid_we", 32'(we), 32'd1);
      chk("rstmid_word", 32'({6'b0, addr, wdata}), 32'h0000_ABCD);
      rst = 1'b0;
      #1;
      chk("rstmid_outputs", 32'({in_ready, we, busy, done, err}), 32'd0);
      chk("rstmid_addr_wdata", 32'({6'b0, addr, wdata}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run_vec(vecs[0], "after_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
